// File: rtl/microwave_pkg.sv
// Shared state encoding and state-only output decode for the microwave timer controller.
package microwave_pkg;

  typedef enum logic [2:0] {
    CLOSED = 3'd0,
    COOK   = 3'd1,
    PAUSE  = 3'd2,
    BELL   = 3'd3,
    OPEN   = 3'd4
  } state_t;

  function automatic logic lamp_on(input state_t s);
    return (s == COOK) || (s == PAUSE) || (s == OPEN);
  endfunction

  function automatic logic bell_on(input state_t s);
    return (s == BELL);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles; holds while disabled.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Microwave oven controller: door/start/stop/add FSM with cook-time countdown, power duty cycle and timed bell.
module microwave_timer_ctrl
  import microwave_pkg::*;
#(
  parameter int unsigned TIME_W     = 8,
  parameter int unsigned TICK_DIV   = 1000,
  parameter int unsigned PWR_LEVELS = 4,
  parameter int unsigned BELL_SEC   = 3,
  parameter int unsigned ADD_SEC    = 30
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              door,
  input  logic                              start,
  input  logic                              stop,
  input  logic                              add,
  input  logic [TIME_W-1:0]                 time_in,
  input  logic [$clog2(PWR_LEVELS+1)-1:0]   power,
  output logic                              heat,
  output logic                              light,
  output logic                              bell,
  output logic [TIME_W-1:0]                 remaining
);

  localparam int unsigned PW = $clog2(PWR_LEVELS + 1);
  localparam int unsigned BW = $clog2(BELL_SEC + 1);
  localparam logic [TIME_W:0]   ADD_EXT = (TIME_W + 1)'(ADD_SEC);
  localparam logic [PW-1:0]     PMAX    = PW'(PWR_LEVELS);

  state_t            state_q, state_d;
  logic [TIME_W-1:0] rem_q, rem_d;
  logic [PW-1:0]     pwr_q, pwr_d;
  logic [PW-1:0]     slot_q, slot_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [TIME_W:0]   sum;
  logic              pre_clr, pre_en, tick;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .en   (pre_en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLOSED;
      rem_q   <= '0;
      pwr_q   <= '0;
      slot_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      pwr_q   <= pwr_d;
      slot_q  <= slot_d;
      bcnt_q  <= bcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    pwr_d   = pwr_q;
    slot_d  = slot_q;
    bcnt_d  = '0;
    pre_clr = 1'b0;
    pre_en  = 1'b0;
    sum     = '0;
    unique case (state_q)
      CLOSED: begin
        if (door) begin
          state_d = OPEN;
        end else if (!stop) begin
          if (start && (time_in != '0)) begin
            state_d = COOK;
            rem_d   = time_in;
            pwr_d   = (power > PMAX) ? PMAX : power;
            slot_d  = '0;
            pre_clr = 1'b1;
          end else if (add) begin
            state_d = COOK;
            rem_d   = ADD_EXT[TIME_W-1:0];
            pwr_d   = PMAX;
            slot_d  = '0;
            pre_clr = 1'b1;
          end
        end
      end
      COOK: begin
        if (door) begin
          state_d = PAUSE;
        end else if (stop) begin
          state_d = CLOSED;
          rem_d   = '0;
        end else begin
          pre_en = 1'b1;
          if (tick) begin
            slot_d = (slot_q == PW'(PWR_LEVELS - 1)) ? '0 : slot_q + PW'(1);
          end
          // Add and tick fold into one saturating update, so add beats the final tick.
          sum   = {1'b0, rem_q} + (add ? ADD_EXT : '0) - {{TIME_W{1'b0}}, tick};
          rem_d = sum[TIME_W] ? '1 : sum[TIME_W-1:0];
          if (sum == '0) begin
            state_d = BELL;
          end
        end
      end
      PAUSE: begin
        if (!door) begin
          state_d = COOK;
        end else if (stop) begin
          state_d = OPEN;
          rem_d   = '0;
        end
      end
      BELL: begin
        if (door) begin
          state_d = OPEN;
        end else if (stop) begin
          state_d = CLOSED;
        end else begin
          // Prescaler wrapped to 0 on the final cook tick, so the bell starts on a clean second.
          pre_en = 1'b1;
          bcnt_d = bcnt_q;
          if (tick) begin
            if (bcnt_q == BW'(BELL_SEC - 1)) begin
              state_d = CLOSED;
            end else begin
              bcnt_d = bcnt_q + BW'(1);
            end
          end
        end
      end
      OPEN: begin
        if (!door) begin
          state_d = CLOSED;
        end
      end
      default: state_d = CLOSED;
    endcase
  end

  assign heat      = (state_q == COOK) && (slot_q < pwr_q);
  assign light     = lamp_on(state_q);
  assign bell      = bell_on(state_q);
  assign remaining = rem_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed and random stimulus for microwave_timer_ctrl, checked against a cycle-count reference model.
module tb_microwave_timer_ctrl;

  localparam int TIME_W     = 8;
  localparam int TICK_DIV   = 4;
  localparam int PWR_LEVELS = 4;
  localparam int BELL_SEC   = 3;
  localparam int ADD_SEC    = 30;
  localparam int PW         = $clog2(PWR_LEVELS + 1);
  localparam int TMAX       = (1 << TIME_W) - 1;

  localparam int M_CLOSED = 0;
  localparam int M_COOK   = 1;
  localparam int M_PAUSE  = 2;
  localparam int M_BELL   = 3;
  localparam int M_OPEN   = 4;

  logic              clk = 1'b0;
  logic              rst, door, start, stop, add;
  logic [TIME_W-1:0] time_in;
  logic [PW-1:0]     power;
  logic              heat, light, bell;
  logic [TIME_W-1:0] remaining;

  int n_pass  = 0;
  int n_total = 0;

  int m_mode, m_rem, m_pw, m_phase, m_ticks, m_bell;

  always #5 clk = ~clk;

  microwave_timer_ctrl #(
    .TIME_W    (TIME_W),
    .TICK_DIV  (TICK_DIV),
    .PWR_LEVELS(PWR_LEVELS),
    .BELL_SEC  (BELL_SEC),
    .ADD_SEC   (ADD_SEC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .door     (door),
    .start    (start),
    .stop     (stop),
    .add      (add),
    .time_in  (time_in),
    .power    (power),
    .heat     (heat),
    .light    (light),
    .bell     (bell),
    .remaining(remaining)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic cook_begin(input int secs, input int pw);
    m_mode  = M_COOK;
    m_rem   = secs;
    m_pw    = pw;
    m_phase = 0;
    m_ticks = 0;
  endtask

  // Advances the model by one clock using the inputs currently driven.
  task automatic model_step();
    int t, nr;
    if (rst) begin
      m_mode = M_CLOSED; m_rem = 0; m_pw = 0; m_phase = 0; m_ticks = 0; m_bell = 0;
      return;
    end
    case (m_mode)
      M_CLOSED: begin
        if (door) m_mode = M_OPEN;
        else if (!stop) begin
          if (start && time_in != 0) cook_begin(int'(time_in), (int'(power) > PWR_LEVELS) ? PWR_LEVELS : int'(power));
          else if (add) cook_begin(ADD_SEC, PWR_LEVELS);
        end
      end
      M_COOK: begin
        if (door) m_mode = M_PAUSE;
        else if (stop) begin m_mode = M_CLOSED; m_rem = 0; end
        else begin
          t = (m_phase == TICK_DIV - 1) ? 1 : 0;
          m_phase = (m_phase + 1) % TICK_DIV;
          m_ticks += t;
          nr = m_rem + (add ? ADD_SEC : 0) - t;
          if (nr > TMAX) nr = TMAX;
          m_rem = nr;
          if (nr == 0) begin m_mode = M_BELL; m_bell = 0; end
        end
      end
      M_PAUSE: begin
        if (!door) m_mode = M_COOK;
        else if (stop) begin m_mode = M_OPEN; m_rem = 0; end
      end
      M_BELL: begin
        if (door) m_mode = M_OPEN;
        else if (stop) m_mode = M_CLOSED;
        else begin
          m_bell++;
          if (m_bell == BELL_SEC * TICK_DIV) m_mode = M_CLOSED;
        end
      end
      default: begin
        if (!door) m_mode = M_CLOSED;
      end
    endcase
  endtask

  task automatic step();
    int exp_heat;
    model_step();
    @(posedge clk);
    #1;
    exp_heat = (m_mode == M_COOK && (m_ticks % PWR_LEVELS) < m_pw) ? 1 : 0;
    chk("heat",      heat,      exp_heat);
    chk("light",     light,     (m_mode == M_COOK || m_mode == M_PAUSE || m_mode == M_OPEN) ? 1 : 0);
    chk("bell",      bell,      (m_mode == M_BELL) ? 1 : 0);
    chk("remaining", remaining, m_rem);
    rst = 0; start = 0; stop = 0; add = 0;
  endtask

  initial begin
    rst = 1; door = 0; start = 0; stop = 0; add = 0; time_in = '0; power = '0;
    m_mode = M_CLOSED; m_rem = 0; m_pw = 0; m_phase = 0; m_ticks = 0; m_bell = 0;
    step();
    chk("rst_light", light, 0);
    chk("rst_rem", remaining, 0);

    // reset in the middle of a cook
    time_in = 8'd5; power = 3'd4; start = 1; step();
    repeat (2) step();
    chk("pre_rst_rem", remaining, 5);
    rst = 1; step();
    chk("midrst_rem", remaining, 0);
    chk("midrst_heat", heat, 0);
    chk("midrst_light", light, 0);

    // full cook with power 2, then bell
    time_in = 8'd3; power = 3'd2; start = 1; step();
    chk("cook_light", light, 1);
    chk("cook_rem3", remaining, 3);
    chk("cook_heat_s0", heat, 1);
    repeat (4) step();
    chk("cook_rem2", remaining, 2);
    chk("cook_heat_s1", heat, 1);
    repeat (4) step();
    chk("cook_rem1", remaining, 1);
    chk("cook_heat_s2", heat, 0);
    repeat (4) step();
    chk("bell_on", bell, 1);
    chk("bell_rem", remaining, 0);
    repeat (11) step();
    chk("bell_hold", bell, 1);
    step();
    chk("bell_off", bell, 0);
    chk("bell_closed_light", light, 0);

    // pause keeps partial second
    time_in = 8'd3; power = 3'd4; start = 1; step();
    repeat (6) step();
    chk("pause_pre_rem", remaining, 2);
    door = 1;
    repeat (10) step();
    chk("pause_heat", heat, 0);
    chk("pause_light", light, 1);
    chk("pause_rem", remaining, 2);
    door = 0; step();
    chk("resume_heat", heat, 1);
    step();
    chk("resume_rem_hold", remaining, 2);
    step();
    chk("resume_tick", remaining, 1);
    stop = 1; step();
    chk("stop_rem", remaining, 0);
    chk("stop_light", light, 0);

    // add saturation, then quick start
    time_in = 8'd250; power = 3'd1; start = 1; step();
    add = 1; step();
    chk("add_sat", remaining, 255);
    stop = 1; step();
    add = 1; step();
    chk("quick_rem", remaining, 30);
    for (int i = 0; i < 9; i++) begin
      chk("quick_heat", heat, 1);
      step();
    end
    stop = 1; step();

    // add coincident with the final tick
    time_in = 8'd1; power = 3'd0; start = 1; step();
    chk("pwr0_heat", heat, 0);
    repeat (3) step();
    add = 1; step();
    chk("add_final_rem", remaining, 30);
    chk("add_final_bell", bell, 0);
    chk("add_final_light", light, 1);
    stop = 1; step();

    // door beats start; zero time ignored; stop in pause opens
    door = 1; start = 1; time_in = 8'd5; step();
    chk("door_start_light", light, 1);
    chk("door_start_rem", remaining, 0);
    door = 0; step();
    time_in = 8'd0; start = 1; step();
    chk("zero_start_light", light, 0);
    time_in = 8'd5; power = 3'd7; start = 1; step();
    door = 1; step();
    stop = 1; step();
    chk("pause_stop_rem", remaining, 0);
    chk("pause_stop_light", light, 1);
    door = 0; step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 2) door = ~door;
      start = ($urandom_range(99) < 6);
      stop  = ($urandom_range(99) < 2);
      add   = ($urandom_range(99) < 4);
      rst   = ($urandom_range(999) < 3);
      if ($urandom_range(9) < 8) time_in = TIME_W'($urandom_range(6));
      else time_in = TIME_W'($urandom_range(255, 220));
      power = PW'($urandom_range(7));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
